// File: rtl/sm3_msg_arb_if.sv
// Bundle of requester, core and result signals around the SM3 message arbiter.
// The arbiter uses the master view because it drives the core input bus.
interface sm3_msg_arb_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int BW    = 4,
  parameter int CNT_W = 16
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ*DW-1:0] req_d;
  logic [N_REQ*BW-1:0] req_vld_byte;
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ-1:0]    req_lst;
  logic [N_REQ-1:0]    req_rdy;
  logic [DW-1:0]       msg_inpt_d;
  logic [BW-1:0]       msg_inpt_vld_byte;
  logic                msg_inpt_vld;
  logic                msg_inpt_lst;
  logic                msg_inpt_rdy;
  logic                cmprss_otpt_vld;
  logic [N_REQ-1:0]    res_owner;
  logic                gnt_vld;
  logic [ID_W-1:0]     gnt_id;
  logic [CNT_W-1:0]    msg_done_cnt;

  modport master (
    input  req_d, req_vld_byte, req_vld, req_lst, msg_inpt_rdy, cmprss_otpt_vld,
    output req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
           res_owner, gnt_vld, gnt_id, msg_done_cnt
  );

  modport slave (
    output req_d, req_vld_byte, req_vld, req_lst, msg_inpt_rdy, cmprss_otpt_vld,
    input  req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
           res_owner, gnt_vld, gnt_id, msg_done_cnt
  );
endinterface

// File: rtl/sm3_msg_arb.sv
// Round-robin arbiter granting the SM3 message input bus one whole message at a time,
// holding the grant until the digest returns and tagging that digest with its owner.
module sm3_msg_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int BW    = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  sm3_msg_arb_if.master bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, XFER, WAIT_RES} state_t;

  state_t           state;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  last_gnt;
  logic [ID_W-1:0]  winner;
  logic             gnt_vld;
  logic             any_req;
  logic             lst_acc;
  logic             digest;
  logic [CNT_W-1:0] done_cnt;
  int               idx;

  // Search upward from the slot after the last served requester so it ends up lowest priority.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_gnt) + k) % N_REQ;
      if (!any_req && bus.req_vld[idx]) begin
        winner  = ID_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign lst_acc = (state == XFER) && bus.req_vld[gnt_id] && bus.msg_inpt_rdy && bus.req_lst[gnt_id];
  assign digest  = (state == WAIT_RES) && bus.cmprss_otpt_vld;

  always_comb begin
    bus.msg_inpt_d        = '0;
    bus.msg_inpt_vld_byte = '0;
    bus.msg_inpt_vld      = 1'b0;
    bus.msg_inpt_lst      = 1'b0;
    bus.req_rdy           = '0;
    bus.res_owner         = '0;
    if (state == XFER) begin
      bus.msg_inpt_d          = bus.req_d[gnt_id*DW +: DW];
      bus.msg_inpt_vld_byte   = bus.req_vld_byte[gnt_id*BW +: BW];
      bus.msg_inpt_vld        = bus.req_vld[gnt_id];
      bus.msg_inpt_lst        = bus.req_lst[gnt_id];
      bus.req_rdy[gnt_id]     = bus.msg_inpt_rdy;
    end
    if (digest) begin
      bus.res_owner = N_REQ'(1) << gnt_id;
    end
  end

  // Stray digest pulses outside WAIT_RES fall through the case without effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_vld  <= 1'b0;
      gnt_id   <= '0;
      last_gnt <= ID_W'(N_REQ - 1);
      done_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id  <= winner;
            gnt_vld <= 1'b1;
            state   <= XFER;
          end
        end
        XFER: begin
          if (lst_acc) begin
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.cmprss_otpt_vld) begin
            last_gnt <= gnt_id;
            done_cnt <= done_cnt + CNT_W'(1);
            gnt_vld  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_vld      = gnt_vld;
  assign bus.gnt_id       = gnt_id;
  assign bus.msg_done_cnt = done_cnt;
endmodule

// File: tb/tb_sm3_msg_arb.sv
// Directed bench for sm3_msg_arb: beats and digest owners are queued when driven
// and compared when the arbiter presents them; the counter is narrowed to exercise wrap.
module tb_sm3_msg_arb;
  localparam int N_REQ = 4;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm3_msg_arb_if #(.N_REQ(N_REQ), .DW(DW), .BW(BW), .CNT_W(CNT_W)) bus ();

  sm3_msg_arb #(.N_REQ(N_REQ), .DW(DW), .BW(BW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int               checks = 0;
  int               passes = 0;
  logic [36:0]      beat_q[$];
  logic [3:0]       own_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [31:0]      beat_d[8];
  logic [3:0]       beat_be[8];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic driveBeat(input int id, input int b, input int n);
    bus.req_d[id*DW +: DW]        = beat_d[b];
    bus.req_vld_byte[id*BW +: BW] = beat_be[b];
    bus.req_lst[id]               = (b == n - 1);
    bus.req_vld[id]               = 1'b1;
  endtask

  // Entered during an IDLE cycle; returns during the first WAIT_RES cycle.
  task automatic applyStimulus(input int id, input int nbeats, input logic [15:0] rdy_pat);
    int          b;
    int          cyc;
    logic [36:0] e;
    logic [3:0]  exp_rdy;
    for (int k = 0; k < nbeats; k++) beat_q.push_back({1'(k == nbeats - 1), beat_be[k], beat_d[k]});
    own_q.push_back(4'(1 << id));
    driveBeat(id, 0, nbeats);
    bus.msg_inpt_rdy = 1'b0;
    #1;
    checkOutput("idle_rdy", 64'(bus.req_rdy), 0);
    checkOutput("idle_vld", 64'(bus.msg_inpt_vld), 0);
    b   = 0;
    cyc = 0;
    while (b < nbeats && cyc < 16) begin
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("gnt_vld", 64'(bus.gnt_vld), 1);
        checkOutput("gnt_id", 64'(bus.gnt_id), 64'(id));
      end
      driveBeat(id, b, nbeats);
      bus.msg_inpt_rdy = rdy_pat[cyc];
      #1;
      exp_rdy = bus.msg_inpt_rdy ? 4'(1 << id) : 4'h0;
      checkOutput("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
      checkOutput("core_vld", 64'(bus.msg_inpt_vld), 1);
      if (bus.msg_inpt_rdy) begin
        e = beat_q.pop_front();
        checkOutput("beat", 64'({bus.msg_inpt_lst, bus.msg_inpt_vld_byte, bus.msg_inpt_d}), 64'(e));
        b++;
      end
      cyc++;
    end
    if (b < nbeats) begin
      checks++;
      $error("[TB] FAIL xfer_timeout beats=%0d required=%0d", b, nbeats);
    end
    @(negedge clk);
    bus.req_vld[id]  = 1'b0;
    bus.req_lst[id]  = 1'b0;
    bus.msg_inpt_rdy = 1'b1;
    #1;
    checkOutput("wait_rdy", 64'(bus.req_rdy), 0);
    checkOutput("wait_vld", 64'(bus.msg_inpt_vld), 0);
    checkOutput("wait_gnt", 64'(bus.gnt_vld), 1);
  endtask

  // Entered during a WAIT_RES cycle; returns during the IDLE cycle after the digest.
  task automatic finishDigest(input int wait_cycles);
    logic [3:0] e;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      #1;
      checkOutput("wait_owner", 64'(bus.res_owner), 0);
      checkOutput("wait_rdy_hold", 64'(bus.req_rdy), 0);
    end
    @(negedge clk);
    bus.cmprss_otpt_vld = 1'b1;
    #1;
    e = own_q.pop_front();
    checkOutput("res_owner", 64'(bus.res_owner), 64'(e));
    exp_cnt++;
    @(negedge clk);
    bus.cmprss_otpt_vld = 1'b0;
    #1;
    checkOutput("done_cnt", 64'(bus.msg_done_cnt), 64'(exp_cnt));
    checkOutput("gnt_cleared", 64'(bus.gnt_vld), 0);
  endtask

  task automatic resetBus();
    bus.req_d           = '0;
    bus.req_vld_byte    = '0;
    bus.req_vld         = '0;
    bus.req_lst         = '0;
    bus.msg_inpt_rdy    = 1'b0;
    bus.cmprss_otpt_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [36:0] e;
    resetBus();

    // Reset held three cycles, then released with no requests.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_gnt_vld", 64'(bus.gnt_vld), 0);
    checkOutput("rst_gnt_id", 64'(bus.gnt_id), 0);
    checkOutput("rst_cnt", 64'(bus.msg_done_cnt), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("idle_outputs", 64'({bus.msg_inpt_vld, bus.msg_inpt_d, bus.req_rdy, bus.res_owner}), 0);
    checkOutput("idle_gnt_vld", 64'(bus.gnt_vld), 0);

    // Requester 2, three beats against a stalling core.
    beat_d[0] = 32'h61626300; beat_be[0] = 4'hF;
    beat_d[1] = 32'h64656600; beat_be[1] = 4'hF;
    beat_d[2] = 32'h67680000; beat_be[2] = 4'hC;
    applyStimulus(2, 3, 16'b1101);
    finishDigest(9);

    // Fresh reset so requester 0 leads, then all four request single-beat messages.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    for (int r = 0; r < N_REQ; r++) begin
      bus.req_d[r*DW +: DW]        = 32'hA000_0000 | 32'(r);
      bus.req_vld_byte[r*BW +: BW] = 4'hF;
    end
    bus.req_lst = '1;
    bus.req_vld = '1;
    for (int m = 0; m < 5; m++) begin
      own_q.push_back(4'(1 << (m % N_REQ)));
      beat_q.push_back({1'b1, 4'hF, 32'hA000_0000 | 32'(m % N_REQ)});
    end
    for (int m = 0; m < 5; m++) begin
      #1;
      checkOutput("rr_idle_rdy", 64'(bus.req_rdy), 0);
      @(negedge clk);
      bus.msg_inpt_rdy = 1'b1;
      #1;
      checkOutput("rr_gnt_id", 64'(bus.gnt_id), 64'(m % N_REQ));
      checkOutput("rr_req_rdy", 64'(bus.req_rdy), 64'(own_q[0]));
      e = beat_q.pop_front();
      checkOutput("rr_beat", 64'({bus.msg_inpt_lst, bus.msg_inpt_vld_byte, bus.msg_inpt_d}), 64'(e));
      @(negedge clk);
      #1;
      checkOutput("rr_wait_rdy", 64'(bus.req_rdy), 0);
      finishDigest(0);
    end
    bus.req_vld = '0;
    bus.req_lst = '0;

    // A digest pulse while idle is ignored.
    @(negedge clk);
    bus.cmprss_otpt_vld = 1'b1;
    #1;
    checkOutput("stray_owner", 64'(bus.res_owner), 0);
    @(negedge clk);
    bus.cmprss_otpt_vld = 1'b0;
    #1;
    checkOutput("stray_cnt", 64'(bus.msg_done_cnt), 64'(exp_cnt));
    checkOutput("stray_gnt", 64'(bus.gnt_vld), 0);

    // Requester 1 arrives while 0 waits for its digest and is served only afterwards.
    beat_d[0] = 32'h0000_00C0; beat_be[0] = 4'h8;
    applyStimulus(0, 1, 16'hFFFF);
    bus.req_d[1*DW +: DW]        = 32'h0000_00C1;
    bus.req_vld_byte[1*BW +: BW] = 4'h8;
    bus.req_lst[1]               = 1'b1;
    bus.req_vld[1]               = 1'b1;
    finishDigest(2);
    beat_d[0] = 32'h0000_00C1;
    applyStimulus(1, 1, 16'hFFFF);
    finishDigest(1);

    // Reset in the middle of a message from requester 3.
    beat_d[0] = 32'h3000_0000; beat_be[0] = 4'hF;
    beat_d[1] = 32'h3000_0001; beat_be[1] = 4'hF;
    beat_d[2] = 32'h3000_0002; beat_be[2] = 4'hF;
    driveBeat(3, 0, 4);
    @(negedge clk);
    bus.msg_inpt_rdy = 1'b1;
    #1;
    checkOutput("mid_gnt_id", 64'(bus.gnt_id), 3);
    checkOutput("mid_rdy0", 64'(bus.req_rdy), 64'(4'b1000));
    @(negedge clk);
    driveBeat(3, 1, 4);
    #1;
    checkOutput("mid_rdy1", 64'(bus.req_rdy), 64'(4'b1000));
    @(negedge clk);
    driveBeat(3, 2, 4);
    bus.msg_inpt_rdy = 1'b0;
    rst = 1'b1;
    bus.req_vld[3] = 1'b0;
    bus.req_lst[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    checkOutput("mid_rst_gnt_vld", 64'(bus.gnt_vld), 0);
    checkOutput("mid_rst_core_vld", 64'(bus.msg_inpt_vld), 0);
    checkOutput("mid_rst_cnt", 64'(bus.msg_done_cnt), 0);
    bus.req_d[1*DW +: DW]        = 32'h0000_00B1;
    bus.req_vld_byte[1*BW +: BW] = 4'hF;
    bus.req_lst[1]               = 1'b1;
    bus.req_vld[1]               = 1'b1;
    beat_d[0] = 32'h0000_00B0; beat_be[0] = 4'hF;
    applyStimulus(0, 1, 16'hFFFF);
    finishDigest(0);
    beat_d[0] = 32'h0000_00B1;
    applyStimulus(1, 1, 16'hFFFF);
    finishDigest(0);

    // Fifteen more messages take the narrowed counter past its wrap to 17 mod 16.
    for (int m = 0; m < 15; m++) begin
      beat_d[0]  = 32'h5000_0000 | 32'(m);
      beat_be[0] = 4'(m);
      applyStimulus(m % N_REQ, 1, 16'hFFFF);
      finishDigest(0);
    end
    checkOutput("cnt_wrap", 64'(bus.msg_done_cnt), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
